// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the decoded round-robin arbiter.
// Imported by the arbiter top and its priority-pick sub-module.
package dec_arb_pkg;
  localparam int NREQ         = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 15;
  localparam int HOLD_W_DEF   = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with an output enable; all-zero when disabled.
module decoder3to8 (
  input  logic [2:0] i_sel,
  input  logic       i_en,
  output logic [7:0] o_y
);
  assign o_y = i_en ? (8'd1 << i_sel) : 8'd0;
endmodule

// File: rtl/rr_pick8.sv
// Combinational rotate-priority search: first set request bit at or after i_ptr.
// Rotates so i_ptr lands at bit 0, priority-encodes, then re-adds i_ptr mod 8.
module rr_pick8
  import dec_arb_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDX_W-1:0]  w_off;

  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_ptr +: NREQ];

  // Descending scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign o_any = |i_req;
  assign o_idx = w_off + i_ptr;
endmodule

// File: rtl/dec_rr_arbiter.sv
// 8-requester round-robin arbiter with a hold-time limit; the registered grant
// index is decoded to a one-hot select for the shared downstream resource.
module dec_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [NREQ-1:0]  grant_oh,
  output logic             preempt,
  output logic             o_dbg_state
);
  // With MAX_HOLD=0 the counter just saturates at all-ones and never times out.
  localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic              r_preempt, w_preempt_nxt;

  logic              w_any;
  logic [IDX_W-1:0]  w_win;
  logic              w_timeout;
  logic              w_owner_req;

  rr_pick8 u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_win)
  );

  assign w_timeout   = (MAX_HOLD != 0) && (r_hold == HOLD_SAT);
  assign w_owner_req = req[r_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && w_any) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_win;
          w_hold_nxt  = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (done || !w_owner_req || w_timeout) begin
          w_state_nxt   = ST_IDLE;
          w_ptr_nxt     = r_idx + 3'd1;
          w_hold_nxt    = '0;
          // Preempt flags only a pure timeout; a coincident release wins.
          w_preempt_nxt = w_timeout && !done && w_owner_req;
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign grant_valid = (r_state == ST_GRANT);
  assign grant_idx   = r_idx;
  assign preempt     = r_preempt;
  assign o_dbg_state = r_state;

  decoder3to8 u_dec (
    .i_sel (r_idx),
    .i_en  (grant_valid),
    .o_y   (grant_oh)
  );
endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Bench for dec_rr_arbiter: directed scenarios plus random traffic, checked
// against an index/pointer-level reference model through an expected queue.
module tb_dec_rr_arbiter;
  localparam int MAXH = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       preempt;
  logic       dbg_state;

  int total = 0;
  int bad   = 0;

  logic [12:0] exp_q[$];

  // Reference model state: owner, rotation pointer, cycles held.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;
  bit m_pre;

  dec_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh),
    .preempt     (preempt),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
    m_pre   = 1'b0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit e, input logic [7:0] r, input bit d);
    bit to;
    bit ex;
    if (!m_valid) begin
      m_pre = 1'b0;
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (!m_valid && r[(m_ptr + k) % 8]) begin
            m_valid = 1'b1;
            m_idx   = (m_ptr + k) % 8;
            m_hold  = 1;
          end
        end
      end
    end else begin
      to = (m_hold == MAXH);
      ex = d || !r[m_idx] || to;
      if (ex) begin
        m_pre   = to && !d && r[m_idx];
        m_ptr   = (m_idx + 1) % 8;
        m_valid = 1'b0;
        m_hold  = 0;
      end else begin
        m_pre  = 1'b0;
        m_hold = (m_hold < MAXH) ? m_hold + 1 : MAXH;
      end
    end
  endtask

  function automatic logic [12:0] pack_exp();
    logic [7:0] oh;
    oh = m_valid ? (8'd1 << m_idx) : 8'd0;
    return {m_valid, 3'(m_idx), oh, m_pre};
  endfunction

  // Driver tasks
  task automatic step_now(input bit e, input logic [7:0] r, input bit d);
    en   = e;
    req  = r;
    done = d;
    model_edge(e, r, d);
    exp_q.push_back(pack_exp());
    @(posedge clk);
  endtask

  task automatic step(input bit e, input logic [7:0] r, input bit d);
    @(negedge clk);
    step_now(e, r, d);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Scoreboard monitor: one expected output snapshot per sampled edge.
  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({grant_valid, grant_idx, grant_oh, preempt} !== e) begin
        bad++;
        $display("FAIL out_cycle t=%0t: got v=%0b idx=%0d oh=%02h pre=%0b want v=%0b idx=%0d oh=%02h pre=%0b",
                 $time, grant_valid, grant_idx, grant_oh, preempt, e[12], e[11:9], e[8:1], e[0]);
      end
    end
  end

  initial begin
    int seq[$];
    int want_seq[4];
    bit prev_v;
    int cnt;
    logic [7:0] r_rand;

    want_seq = '{2, 5, 7, 2};

    // 1. Reset behaviour
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", grant_valid, 0);
    chk("rst_oh", grant_oh, 0);
    chk("rst_preempt", preempt, 0);
    chk("rst_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_now(1, 8'hFF, 0);
    #2;
    chk("first_idx", grant_idx, 0);
    chk("first_oh", grant_oh, 8'h01);
    step(1, 8'hFF, 1);

    // 2. Rotation with done on each grant
    prev_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hA4, m_valid);
      #2;
      if (grant_valid && !prev_v) seq.push_back(int'(grant_idx));
      prev_v = grant_valid;
    end
    chk("rot_count", seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) chk("rot_owner", seq[i], want_seq[i]);
    end

    // 3. Wrap-around from ptr=7
    step(1, 8'h40, 0);
    step(1, 8'h40, 1);
    step(1, 8'h03, 0);
    #2;
    chk("wrap_idx", grant_idx, 0);
    chk("wrap_oh", grant_oh, 8'h01);
    step(1, 8'h03, 1);
    step(1, 8'h03, 0);
    #2;
    chk("wrap_next", grant_idx, 1);
    step(1, 8'h03, 1);

    // 4. Timeout after MAX_HOLD cycles
    step(1, 8'h09, 0);
    #2;
    chk("to_owner", grant_idx, 3);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step(1, 8'h09, 0);
      #2;
      if (!grant_valid) break;
      cnt++;
    end
    chk("to_hold_cycles", cnt, MAXH);
    chk("to_preempt", preempt, 1);
    step(1, 8'h09, 0);
    #2;
    chk("to_next_owner", grant_idx, 0);
    chk("to_preempt_pulse", preempt, 0);
    step(1, 8'h09, 1);

    // 5. en low keeps grant; withdrawal exits; no new grants until en returns
    step(1, 8'h40, 0);
    repeat (4) step(0, 8'h40, 0);
    #2;
    chk("en_hold_valid", grant_valid, 1);
    chk("en_hold_idx", grant_idx, 6);
    step(0, 8'h00, 0);
    repeat (4) step(0, 8'hFF, 0);
    #2;
    chk("en_block", grant_valid, 0);
    step(1, 8'hFF, 0);
    #2;
    chk("en_resume_idx", grant_idx, 7);
    step(1, 8'hFF, 1);

    // 6. Asynchronous reset mid-grant
    step(1, 8'h20, 0);
    step(1, 8'h20, 0);
    #3;
    chk("pre_arst_idx", grant_idx, 5);
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    chk("arst_valid", grant_valid, 0);
    chk("arst_oh", grant_oh, 0);
    chk("arst_idx", grant_idx, 0);
    chk("arst_preempt", preempt, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step_now(1, 8'hFF, 0);
    #2;
    chk("arst_ptr_zero", grant_idx, 0);
    step(1, 8'hFF, 1);

    // Random traffic
    r_rand = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) r_rand = 8'($urandom_range(0, 255));
      step($urandom_range(0, 9) != 0, r_rand, $urandom_range(0, 19) == 0);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
